// File: rtl/inst_sequencer_pkg.sv
// Types private to the instruction sequencer.
package inst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sa_share_pkg.sv
// Shared systolic-array instruction format: word width, program-memory width,
// opcode field position and the IDLE opcode.
package sa_share_pkg;

    localparam int unsigned INST_BITS   = 16;
    localparam int unsigned PC_BITS     = 8;
    localparam int unsigned OPCODE_MSB  = 15;
    localparam int unsigned OPCODE_LSB  = 12;
    localparam int unsigned OPCODE_BITS = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_BITS-1:0] IDLE_INST = 4'hF;

endpackage

// File: rtl/inst_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no reset
// so the program survives a sequencer reset.
module inst_mem #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Issues a host-loaded program one word at a time to the control unit, advancing
// only when the control unit signals ready and pausing on halt.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int unsigned INST_BITS = sa_share_pkg::INST_BITS,
    parameter int unsigned PC_BITS   = sa_share_pkg::PC_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 host_we,
    input  logic [PC_BITS-1:0]   host_addr,
    input  logic [INST_BITS-1:0] host_inst,
    input  logic [PC_BITS:0]     prog_len,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 flag,
    output logic [INST_BITS-1:0] instruction,
    output logic [PC_BITS:0]     pc,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_BITS = PC_BITS + 1;
    localparam logic [INST_BITS-1:0] IDLE_WORD =
        INST_BITS'(sa_share_pkg::IDLE_INST) << sa_share_pkg::OPCODE_LSB;

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic [INST_BITS-1:0] instruction_d;
    logic [CNT_BITS-1:0]  pc_d;
    logic [CNT_BITS-1:0]  len_q;
    logic [CNT_BITS-1:0]  len_d;
    logic                 busy_d;
    logic                 done_d;

    logic                 mem_we_c;
    logic [PC_BITS-1:0]   rd_addr_c;
    logic [INST_BITS-1:0] rd_word_c;

    // Host loads are only accepted while no program is running.
    assign mem_we_c  = host_we && (state_q == ST_IDLE);
    // A start from IDLE always fetches address 0, whatever pc was left at.
    assign rd_addr_c = (state_q == ST_IDLE) ? '0 : pc[PC_BITS-1:0];

    inst_mem #(
        .DATA_BITS (INST_BITS),
        .ADDR_BITS (PC_BITS)
    ) u_inst_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (host_addr),
        .wdata   (host_inst),
        .raddr   (rd_addr_c),
        .rdata_c (rd_word_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction;
        pc_d          = pc;
        len_d         = len_q;
        done_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                instruction_d = IDLE_WORD;
                if (start) begin
                    len_d = prog_len;
                    pc_d  = '0;
                    if (prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        if (!halt) begin
                            instruction_d = rd_word_c;
                            pc_d          = CNT_BITS'(1);
                        end
                    end
                end
            end
            ST_RUN: begin
                // flag low: hold the word so multi-cycle instructions see it stable.
                if (flag) begin
                    if (halt) begin
                        instruction_d = IDLE_WORD;
                    end else if (pc < len_q) begin
                        instruction_d = rd_word_c;
                        pc_d          = pc + CNT_BITS'(1);
                    end else begin
                        instruction_d = IDLE_WORD;
                        state_d       = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (flag) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instruction_d = IDLE_WORD;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            instruction <= IDLE_WORD;
            pc          <= '0;
            len_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            instruction <= instruction_d;
            pc          <= pc_d;
            len_q       <= len_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule
